// File: rtl/m6809_sys_ctrl.sv
// m6809_sys_ctrl: CPU reset sequencing, halt arbitration against the 6809
// HALT/BA/BS handshake, single stepping and a run-cycle budget.
module m6809_sys_ctrl #(
   parameter int RESET_CYCLES = 4,
   parameter int N_HALT = 2,
   parameter int RUN_CYCLES = 250,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   output logic              cpu_reset_b,
   output logic              cpu_halt_b,
   input  logic              cpu_ba,
   input  logic              cpu_bs,
   input  logic [N_HALT-1:0] halt_req,
   output logic [N_HALT-1:0] halt_gnt,
   input  logic              step_mode,
   input  logic              step_pulse,
   output logic              run_done,
   output logic [CNT_W-1:0]  cycle_count
);
   typedef enum logic [2:0] {RESET_HOLD, RUN, HALT_PEND, HALTED, STEP, DONE} state_t;
   state_t state;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [N_HALT-1:0] lowest;
   logic step_q;
   logic ack;
   logic any_req;
   logic step_rise;
   logic budget_hit;
   assign ack = cpu_ba & cpu_bs;
   assign any_req = |halt_req;
   assign step_rise = step_pulse & ~step_q;
   assign budget_hit = (RUN_CYCLES != 0) && (cycle_count == CNT_W'(RUN_CYCLES - 1));
   assign cnt_next = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
   // isolate the lowest set request bit
   assign lowest = halt_req & (~halt_req + N_HALT'(1));
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RESET_HOLD;
         cpu_reset_b <= 1'b0;
         cpu_halt_b  <= 1'b1;
         halt_gnt    <= '0;
         run_done    <= 1'b0;
         cycle_count <= '0;
         hold_cnt    <= '0;
         step_q      <= 1'b0;
      end else begin
         step_q <= step_pulse;
         case (state)
            RESET_HOLD:
               if (hold_cnt == CNT_W'(RESET_CYCLES - 1)) begin
                  state       <= RUN;
                  cpu_reset_b <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            RUN, STEP: begin
               cycle_count <= cnt_next;
               if (budget_hit) begin
                  state      <= DONE;
                  run_done   <= 1'b1;
                  cpu_halt_b <= 1'b0;
               end else if (state == RUN ? (any_req || step_mode) : !cpu_ba) begin
                  state      <= HALT_PEND;
                  cpu_halt_b <= 1'b0;
               end
            end
            HALT_PEND:
               if (ack) begin
                  state <= HALTED;
               end else if (!any_req && !step_mode) begin
                  state      <= RUN;
                  cpu_halt_b <= 1'b1;
               end
            HALTED:
               if (|halt_gnt) begin
                  if (!(|(halt_gnt & halt_req))) halt_gnt <= '0;
               end else if (any_req) begin
                  halt_gnt <= lowest;
               end else if (!step_mode || step_rise) begin
                  state      <= step_mode ? STEP : RUN;
                  cpu_halt_b <= 1'b1;
               end
            default: begin
               halt_gnt   <= '0;
               cpu_halt_b <= 1'b0;
               run_done   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_m6809_sys_ctrl.sv
// tb_m6809_sys_ctrl: directed stimulus pushes cycle-tagged expectations into a
// scoreboard; a negedge monitor compares them; a small 6809 model answers HALT.
module tb_m6809_sys_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cpu_reset_b, cpu_halt_b;
   logic cpu_ba = 1'b0, cpu_bs = 1'b0;
   logic [1:0] halt_req = '0;
   logic [1:0] halt_gnt;
   logic step_mode = 1'b0, step_pulse = 1'b0;
   logic run_done;
   logic [15:0] cycle_count;
   logic model_en = 1'b1;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int lo = 0, hi = 0;

   typedef struct {
      int cyc;
      string nm;
      logic [4:0] m;
      logic rb;
      logic hb;
      logic [1:0] g;
      logic d;
      logic [15:0] cnt;
   } exp_t;
   exp_t sb[$];

   m6809_sys_ctrl dut (
      .clk(clk), .reset(reset), .cpu_reset_b(cpu_reset_b), .cpu_halt_b(cpu_halt_b),
      .cpu_ba(cpu_ba), .cpu_bs(cpu_bs), .halt_req(halt_req), .halt_gnt(halt_gnt),
      .step_mode(step_mode), .step_pulse(step_pulse), .run_done(run_done),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CPU model: acks after three halted cycles, keeps BA up for three cycles once released
   always @(negedge clk) begin
      if (!cpu_halt_b) begin lo++; hi = 0; end else begin hi++; lo = 0; end
      cpu_ba = model_en && ((!cpu_halt_b && lo >= 3) || (cpu_halt_b && cpu_ba && hi < 3));
      cpu_bs = cpu_ba;
   end

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            exp_t e;
            e = sb[i];
            sb.delete(i);
            total++;
            if (e.cyc < cyc || (e.m[4] && cpu_reset_b !== e.rb) || (e.m[3] && cpu_halt_b !== e.hb) ||
                (e.m[2] && halt_gnt !== e.g) || (e.m[1] && run_done !== e.d) ||
                (e.m[0] && cycle_count !== e.cnt)) begin
               bad++;
               $display("FAIL %s cyc=%0d got rb=%b hb=%b gnt=%b done=%b cnt=%0d want(mask=%b) rb=%b hb=%b gnt=%b done=%b cnt=%0d",
                        e.nm, cyc, cpu_reset_b, cpu_halt_b, halt_gnt, run_done, cycle_count,
                        e.m, e.rb, e.hb, e.g, e.d, e.cnt);
            end
         end
      end
   end

   task automatic want(input int c, input string nm, input logic [4:0] m, input logic rb,
                       input logic hb, input logic [1:0] g, input logic d, input logic [15:0] cnt);
      exp_t e;
      e.cyc = c; e.nm = nm; e.m = m; e.rb = rb; e.hb = hb; e.g = g; e.d = d; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset(output int r);
      @(negedge clk);
      reset = 1'b1;
      halt_req = '0; step_mode = 1'b0; step_pulse = 1'b0; model_en = 1'b1;
      want(cyc + 1, "reset_values", 5'b11111, 1'b0, 1'b1, 2'b00, 1'b0, 16'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      r = cyc;
   endtask

   initial begin
      int r;
      // reset sequence
      do_reset(r);
      want(r + 3, "rst_hold", 5'b11001, 1'b0, 1'b1, 2'b00, 1'b0, 16'd0);
      want(r + 4, "rst_release", 5'b11001, 1'b1, 1'b1, 2'b00, 1'b0, 16'd0);
      want(r + 5, "count_start", 5'b00001, 1'b0, 1'b0, 2'b00, 1'b0, 16'd1);
      want(r + 9, "count_run", 5'b01111, 1'b0, 1'b1, 2'b00, 1'b0, 16'd5);
      wait_until(r + 10);
      // halt handshake with two requesters
      do_reset(r);
      want(r + 7, "halt_lat", 5'b01101, 1'b0, 1'b0, 2'b00, 1'b0, 16'd3);
      want(r + 10, "pre_grant", 5'b01100, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
      want(r + 11, "grant0", 5'b01101, 1'b0, 1'b0, 2'b01, 1'b0, 16'd3);
      want(r + 14, "release0", 5'b00100, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
      want(r + 15, "grant1", 5'b01100, 1'b0, 1'b0, 2'b10, 1'b0, 16'd0);
      want(r + 18, "release1", 5'b01100, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
      want(r + 19, "resume", 5'b01101, 1'b0, 1'b1, 2'b00, 1'b0, 16'd3);
      want(r + 20, "resume_cnt", 5'b00001, 1'b0, 1'b0, 2'b00, 1'b0, 16'd4);
      wait_until(r + 6);  halt_req = 2'b11;
      wait_until(r + 13); halt_req = 2'b10;
      wait_until(r + 17); halt_req = 2'b00;
      wait_until(r + 21);
      // abandoned halt, no ack from the CPU
      do_reset(r);
      model_en = 1'b0;
      want(r + 7, "abandon_pend", 5'b01100, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
      want(r + 8, "abandon_wait", 5'b01100, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
      want(r + 9, "abandon_run", 5'b01101, 1'b0, 1'b1, 2'b00, 1'b0, 16'd3);
      want(r + 12, "abandon_cnt", 5'b01101, 1'b0, 1'b1, 2'b00, 1'b0, 16'd6);
      wait_until(r + 6); halt_req = 2'b10;
      wait_until(r + 8); halt_req = 2'b00;
      wait_until(r + 13);
      // single stepping
      do_reset(r);
      want(r + 12, "step_halted", 5'b01101, 1'b0, 1'b0, 2'b00, 1'b0, 16'd3);
      want(r + 13, "step1_go", 5'b01001, 1'b0, 1'b1, 2'b00, 1'b0, 16'd3);
      want(r + 15, "step1_run", 5'b01001, 1'b0, 1'b1, 2'b00, 1'b0, 16'd5);
      want(r + 16, "step1_stop", 5'b01001, 1'b0, 1'b0, 2'b00, 1'b0, 16'd6);
      want(r + 20, "step_idle", 5'b01001, 1'b0, 1'b0, 2'b00, 1'b0, 16'd6);
      want(r + 21, "step2_go", 5'b01000, 1'b0, 1'b1, 2'b00, 1'b0, 16'd0);
      want(r + 24, "step2_stop", 5'b01001, 1'b0, 1'b0, 2'b00, 1'b0, 16'd9);
      want(r + 40, "step_held", 5'b01101, 1'b0, 1'b0, 2'b00, 1'b0, 16'd9);
      wait_until(r + 6);  step_mode = 1'b1;
      wait_until(r + 12); step_pulse = 1'b1;
      wait_until(r + 14); step_pulse = 1'b0;
      wait_until(r + 20); step_pulse = 1'b1;
      wait_until(r + 41);
      // run budget expiry
      do_reset(r);
      want(r + 253, "budget_pre", 5'b01011, 1'b0, 1'b1, 2'b00, 1'b0, 16'd249);
      want(r + 254, "budget_hit", 5'b01111, 1'b0, 1'b0, 2'b00, 1'b1, 16'd250);
      want(r + 260, "budget_frozen", 5'b01111, 1'b0, 1'b0, 2'b00, 1'b1, 16'd250);
      wait_until(r + 261);
      // budget expiry coinciding with a halt request
      do_reset(r);
      want(r + 254, "race_done", 5'b01111, 1'b0, 1'b0, 2'b00, 1'b1, 16'd250);
      want(r + 258, "race_nogrant", 5'b00110, 1'b0, 1'b0, 2'b00, 1'b1, 16'd0);
      want(r + 266, "race_nogrant2", 5'b01111, 1'b0, 1'b0, 2'b00, 1'b1, 16'd250);
      wait_until(r + 253); halt_req = 2'b11;
      wait_until(r + 267);
      // reset while a grant is held
      do_reset(r);
      want(r + 11, "pre_rst_grant", 5'b00101, 1'b0, 1'b0, 2'b01, 1'b0, 16'd3);
      want(r + 12, "pre_rst_hold", 5'b00100, 1'b0, 1'b0, 2'b01, 1'b0, 16'd0);
      wait_until(r + 6); halt_req = 2'b11;
      wait_until(r + 11);
      do_reset(r);
      want(r + 4, "rerelease", 5'b11111, 1'b1, 1'b1, 2'b00, 1'b0, 16'd0);
      wait_until(r + 6);
      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         bad += sb.size();
         $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time=%0t required=finish", $time);
      $fatal(1);
   end
endmodule
